// File: rtl/peripheral_div_if.sv
// CPU data-bus slice seen by the memory-mapped divider: strobes, offset, write data and read data.
interface peripheral_div_if;
  logic [15:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_div.sv
// Memory-mapped sequential unsigned divider: one restoring step per clock, firmware polls STATUS.
// Map: 0x00 A, 0x04 B, 0x08 CTRL/STATUS, 0x0C QUOT, 0x10 REM; d_out is registered.
module peripheral_div #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  peripheral_div_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic [WIDTH-1:0] rem_acc_reg, quo_acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dz_reg;
  logic [31:0]      d_out_reg;

  logic busy, done;
  logic wr_en, wr_a, wr_b, start;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff, rem_step, quo_step;
  logic [31:0]      rd_data;

  // Operand and control writes are locked out while a division is in flight.
  assign wr_en = bus.cs & bus.wr;
  assign wr_a  = wr_en && (bus.addr == 5'h00) && !busy;
  assign wr_b  = wr_en && (bus.addr == 5'h04) && !busy;
  assign start = wr_en && (bus.addr == 5'h08) && bus.d_in[0] && !busy;

  // One restoring step: when t >= B the true difference is below B, so WIDTH bits suffice.
  assign trial    = {rem_acc_reg, quo_acc_reg[WIDTH-1]};
  assign fits     = trial >= {1'b0, b_reg};
  assign diff     = trial[WIDTH-1:0] - b_reg;
  assign rem_step = fits ? diff : trial[WIDTH-1:0];
  assign quo_step = {quo_acc_reg[WIDTH-2:0], fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      rem_acc_reg <= '0;
      quo_acc_reg <= '0;
      cnt_reg     <= '0;
      dz_reg      <= 1'b0;
    end else begin
      if (wr_a) a_reg <= bus.d_in[WIDTH-1:0];
      if (wr_b) b_reg <= bus.d_in[WIDTH-1:0];
      if (start) begin
        rem_acc_reg <= '0;
        quo_acc_reg <= a_reg;
        cnt_reg     <= CW'(WIDTH - 1);
        dz_reg      <= (b_reg == '0);
      end else if (busy) begin
        rem_acc_reg <= rem_step;
        quo_acc_reg <= quo_step;
        cnt_reg     <= cnt_reg - 1'b1;
        // Results are published together with the last step, never partially.
        if (cnt_reg == '0) begin
          quot_reg <= quo_step;
          rem_reg  <= rem_step;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      5'h00:   rd_data[WIDTH-1:0] = a_reg;
      5'h04:   rd_data[WIDTH-1:0] = b_reg;
      5'h08:   rd_data[2:0]       = {dz_reg, done, busy};
      5'h0C:   rd_data[WIDTH-1:0] = quot_reg;
      5'h10:   rd_data[WIDTH-1:0] = rem_reg;
      default: rd_data = '0;
    endcase
  end

  // Reads sample pre-edge register values, so a same-cycle write shows up one read later.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_reg <= '0;
    end else if (bus.cs && bus.rd) begin
      d_out_reg <= rd_data;
    end
  end

  assign bus.d_out = d_out_reg;

endmodule

// File: tb/tb_peripheral_div.sv
// Self-checking bench for peripheral_div: vector table, hand-written corner sequences, random sweep.
module tb_peripheral_div;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  peripheral_div_if bus ();

  peripheral_div #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic [31:0] st;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cs   = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    bus.addr = 5'h00;
    bus.d_in = 16'h0;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [15:0] data);
    bus.cs   = 1'b1;
    bus.wr   = 1'b1;
    bus.rd   = 1'b0;
    bus.addr = addr;
    bus.d_in = data;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    bus.cs   = 1'b1;
    bus.wr   = 1'b0;
    bus.rd   = 1'b1;
    bus.addr = addr;
    @(posedge clk);
    #1;
    data = bus.d_out;
    bus_idle();
  endtask

  // Polls STATUS each cycle; busy_cycles counts the reads that still showed busy.
  task automatic poll_done(output logic [31:0] st, output int busy_cycles);
    logic [31:0] d;
    busy_cycles = 0;
    bus_read(5'h08, d);
    while (d[0] && busy_cycles < 40) begin
      busy_cycles++;
      bus_read(5'h08, d);
    end
    st = d;
  endtask

  task automatic div_run(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [31:0] st, output int busy_cycles);
    bus_write(5'h00, a);
    bus_write(5'h04, b);
    bus_write(5'h08, 16'h0001);
    poll_done(st, busy_cycles);
    bus_read(5'h0C, q);
    bus_read(5'h10, r);
    $display("div a=%0d b=%0d -> q=%0d r=%0d status=0x%0h busy=%0d", a, b, q, r, st, busy_cycles);
  endtask

  // Reference: plain integer division; divide-by-zero gives all-ones and the dividend.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a, ub = b;
    if (ub == 0) return 16'hFFFF;
    return 16'(ua / ub);
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a, ub = b;
    if (ub == 0) return a;
    return 16'(ua % ub);
  endfunction

  initial begin
    logic [31:0] q, r, st, d;
    logic [15:0] last_q, last_r, ra, rb;
    int          bc;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,    r: 16'd2,     st: 32'h2};
    vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,  r: 16'd0,     st: 32'h2};
    vecs[2] = '{a: 16'd3,     b: 16'h8000,   q: 16'd0,     r: 16'd3,     st: 32'h2};
    vecs[3] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,     r: 16'd0,     st: 32'h2};
    vecs[4] = '{a: 16'd5,     b: 16'd0,      q: 16'hFFFF,  r: 16'd5,     st: 32'h6};
    vecs[5] = '{a: 16'd1000,  b: 16'd10,     q: 16'd100,   r: 16'd0,     st: 32'h2};
    vecs[6] = '{a: 16'd60000, b: 16'd7,      q: 16'd8571,  r: 16'd3,     st: 32'h2};
    vecs[7] = '{a: 16'd1,     b: 16'd1,      q: 16'd1,     r: 16'd0,     st: 32'h2};
    vecs[8] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,     r: 16'd0,     st: 32'h2};
    vecs[9] = '{a: 16'hFFFE,  b: 16'hFFFF,   q: 16'd0,     r: 16'hFFFE,  st: 32'h2};

    bus_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_dout", bus.d_out, 32'h0);
    bus_read(5'h00, d); check("reset_A", d, 32'h0);
    bus_read(5'h04, d); check("reset_B", d, 32'h0);
    bus_read(5'h08, d); check("reset_status", d, 32'h0);
    bus_read(5'h0C, d); check("reset_quot", d, 32'h0);
    bus_read(5'h10, d); check("reset_rem", d, 32'h0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      div_run(vecs[i].a, vecs[i].b, q, r, st, bc);
      check($sformatf("vec%0d_quot", i), q, {16'h0, vecs[i].q});
      check($sformatf("vec%0d_rem", i), r, {16'h0, vecs[i].r});
      check($sformatf("vec%0d_status", i), st, vecs[i].st);
      check($sformatf("vec%0d_busy_cycles", i), bc, 32'd16);
    end
    last_q = vecs[9].q;
    last_r = vecs[9].r;

    // Writes while busy are ignored; results keep old values until done
    bus_write(5'h00, 16'd1000);
    bus_write(5'h04, 16'd10);
    bus_write(5'h08, 16'h0001);
    bus_read(5'h0C, d); check("busy_quot_old", d, {16'h0, last_q});
    bus_read(5'h10, d); check("busy_rem_old", d, {16'h0, last_r});
    bus_read(5'h08, d); check("busy_status", d, 32'h1);
    bus_read(5'h08, d);
    bus_write(5'h00, 16'd7);
    bus_write(5'h08, 16'h0001);
    poll_done(st, bc);
    check("busy_wr_remaining_busy", bc, 32'd10);
    check("busy_wr_status", st, 32'h2);
    bus_read(5'h0C, d); check("busy_wr_quot", d, 32'd100);
    bus_read(5'h10, d); check("busy_wr_rem", d, 32'd0);
    bus_read(5'h00, d); check("busy_wr_A", d, 32'd1000);
    $display("busy-write sequence: quot/rem checked after ignored writes");

    // Reset in the middle of a run
    bus_write(5'h00, 16'd60000);
    bus_write(5'h04, 16'd7);
    bus_write(5'h08, 16'h0001);
    for (int i = 0; i < 7; i++) bus_read(5'h00, d);
    check("midrst_dout_before", bus.d_out, 32'd60000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_dout", bus.d_out, 32'h0);
    bus_read(5'h08, d); check("midrst_status", d, 32'h0);
    bus_read(5'h0C, d); check("midrst_quot", d, 32'h0);
    bus_read(5'h10, d); check("midrst_rem", d, 32'h0);
    bus_read(5'h00, d); check("midrst_A", d, 32'h0);
    div_run(16'd60000, 16'd7, q, r, st, bc);
    check("after_rst_quot", q, 32'd8571);
    check("after_rst_rem", r, 32'd3);

    // Unmapped reads, same-cycle write+read, deselected writes, start with bit0 clear
    bus_write(5'h00, 16'h1234);
    bus_read(5'h00, d); check("readback_A", d, 32'h1234);
    bus_read(5'h14, d); check("unmapped_14", d, 32'h0);
    bus_read(5'h00, d);
    bus_read(5'h1C, d); check("unmapped_1C", d, 32'h0);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 5'h00; bus.d_in = 16'h5678;
    @(posedge clk);
    #1;
    d = bus.d_out;
    bus_idle();
    check("wr_rd_same_cycle_dout", d, 32'h1234);
    bus_read(5'h00, d); check("wr_rd_same_cycle_A", d, 32'h5678);
    bus.cs = 1'b0; bus.wr = 1'b1; bus.addr = 5'h00; bus.d_in = 16'hBEEF;
    @(posedge clk); #1;
    bus.addr = 5'h04;
    @(posedge clk); #1;
    bus.addr = 5'h08; bus.d_in = 16'h0001;
    @(posedge clk); #1;
    bus_idle();
    bus_read(5'h00, d); check("cs0_A", d, 32'h5678);
    bus_read(5'h04, d); check("cs0_B", d, 32'd7);
    bus_read(5'h08, d); check("cs0_status", d, 32'h2);
    bus_write(5'h08, 16'h0000);
    bus_read(5'h08, d); check("start0_status", d, 32'h2);
    bus_read(5'h0C, d); check("start0_quot", d, 32'd8571);

    // Random sweep against the arithmetic reference
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 15));
      if (rb == 16'h0) rb = 16'h1;
      div_run(ra, rb, q, r, st, bc);
      check($sformatf("rnd%0d_quot a=%0d b=%0d", i, ra, rb), q, {16'h0, ref_q(ra, rb)});
      check($sformatf("rnd%0d_rem a=%0d b=%0d", i, ra, rb), r, {16'h0, ref_r(ra, rb)});
      check($sformatf("rnd%0d_status", i), st, 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
